// File: rtl/fb_blitter.sv
// fb_blitter: rectangle copy from source RAM into a framebuffer with clipping and colour keying.
module fb_blitter #(
  parameter int FB_W = 240,
  parameter int FB_H = 160
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [8:0]  i_cmd_dst_x,
  input  logic [8:0]  i_cmd_dst_y,
  input  logic [8:0]  i_cmd_w,
  input  logic [8:0]  i_cmd_h,
  input  logic [18:0] i_cmd_src_base,
  input  logic [9:0]  i_cmd_src_stride,
  input  logic        i_cmd_key_en,
  input  logic [23:0] i_cmd_key,
  output logic [18:0] o_src_addr,
  input  logic [23:0] i_src_data,
  input  logic        i_wr_allow,
  output logic [15:0] o_fb_addr,
  output logic [23:0] o_fb_data,
  output logic        o_fb_we,
  output logic        o_busy,
  output logic        o_done
);
  localparam logic [9:0] W10 = 10'(FB_W);
  localparam logic [9:0] H10 = 10'(FB_H);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [8:0]  r_dx, r_dy, r_w, r_h, r_col, r_row;
  logic [9:0]  r_stride;
  logic        r_key_en, r_fb_we, r_done;
  logic [23:0] r_key, r_fb_data;
  logic [18:0] r_ptr, r_row_base;
  logic [15:0] r_fb_addr;
  logic        w_accept, w_consume, w_eol, w_last, w_empty, w_fin, w_wr;
  logic [9:0]  w_x, w_y;
  logic [18:0] w_row_next, w_ptr_next;
  logic [31:0] w_lin;
  always_comb begin
    w_accept    = i_cmd_valid && r_state == S_IDLE;
    w_consume   = r_state == S_RUN && i_wr_allow;
    w_empty     = r_w == 9'd0 || r_h == 9'd0;
    w_eol       = r_col == r_w - 9'd1;
    w_last      = w_eol && r_row == r_h - 9'd1;
    w_row_next  = r_row_base + 19'(r_stride);
    w_ptr_next  = w_eol ? w_row_next : r_ptr + 19'd1;
    // Hold the current pixel's address while stalled so its data is re-presented next cycle.
    o_src_addr  = w_consume ? w_ptr_next : r_ptr;
    w_x         = {1'b0, r_dx} + {1'b0, r_col};
    w_y         = {1'b0, r_dy} + {1'b0, r_row};
    w_lin       = 32'(w_y) * 32'(FB_W) + 32'(w_x);
    w_wr        = w_consume && w_x < W10 && w_y < H10 && !(r_key_en && i_src_data == r_key);
    w_fin       = (r_state == S_PRIME && w_empty) || (w_consume && w_last);
    w_state_nxt = r_state == S_IDLE  ? (w_accept ? S_PRIME : S_IDLE) :
                  r_state == S_PRIME ? (w_empty ? S_IDLE : S_RUN) :
                  (w_consume && w_last) ? S_IDLE : S_RUN;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
      r_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin;
      r_fb_we <= w_wr;
      if (w_wr) begin
        r_fb_addr <= w_lin[15:0];
        r_fb_data <= i_src_data;
      end
      if (w_accept) begin
        r_dx       <= i_cmd_dst_x;
        r_dy       <= i_cmd_dst_y;
        r_w        <= i_cmd_w;
        r_h        <= i_cmd_h;
        r_stride   <= i_cmd_src_stride;
        r_key_en   <= i_cmd_key_en;
        r_key      <= i_cmd_key;
        r_ptr      <= i_cmd_src_base;
        r_row_base <= i_cmd_src_base;
        r_col      <= '0;
        r_row      <= '0;
      end
      if (w_consume) begin
        r_col <= w_eol ? 9'd0 : r_col + 9'd1;
        r_row <= w_eol ? r_row + 9'd1 : r_row;
        r_ptr <= w_ptr_next;
        if (w_eol) r_row_base <= w_row_next;
      end
    end
  end
  assign o_cmd_ready = r_state == S_IDLE;
  assign o_busy      = r_state != S_IDLE;
  assign o_done      = r_done;
  assign o_fb_we     = r_fb_we;
  assign o_fb_addr   = r_fb_addr;
  assign o_fb_data   = r_fb_data;
endmodule

// File: tb/tb_fb_blitter.sv
// tb_fb_blitter: directed checks of fb_blitter against hand-computed addresses, data and latencies.
module tb_fb_blitter;
  logic        clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [8:0]  dst_x = 0, dst_y = 0, w = 0, h = 0;
  logic [18:0] src_base = 0, src_addr;
  logic [9:0]  stride = 0;
  logic        key_en = 0, wr_allow = 1, fb_we, busy, done;
  logic [23:0] key = 0, src_data = 0, fb_data;
  logic [15:0] fb_addr;
  logic [23:0] mem [0:1023];
  logic [39:0] wq [$];
  int          n_err = 0, n_chk = 0, n_done = 0, n;

  fb_blitter dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_dst_x(dst_x), .i_cmd_dst_y(dst_y), .i_cmd_w(w), .i_cmd_h(h),
    .i_cmd_src_base(src_base), .i_cmd_src_stride(stride), .i_cmd_key_en(key_en), .i_cmd_key(key),
    .o_src_addr(src_addr), .i_src_data(src_data), .i_wr_allow(wr_allow),
    .o_fb_addr(fb_addr), .o_fb_data(fb_data), .o_fb_we(fb_we), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) src_data <= mem[src_addr[9:0]];
  always @(negedge clk) begin
    if (fb_we) wq.push_back({fb_addr, fb_data});
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input int x, y, cw, ch, base, str, input logic ken, input logic [23:0] k);
    dst_x = 9'(x); dst_y = 9'(y); w = 9'(cw); h = 9'(ch);
    src_base = 19'(base); stride = 10'(str); key_en = ken; key = k;
    cmd_valid = 1;
  endtask

  task automatic wait_done(input logic [31:0] pat, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      cmd_valid = 0;
      dst_x = 9'h1FF; w = 9'h1FF;
      wr_allow = pat[cnt[4:0]];
    end while (!done && cnt < 300);
    wr_allow = 1;
    chk("done_seen", 48'(done), 48'd1);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  task automatic run_t1(input string tag);
    wq.delete();
    cmd(10, 20, 4, 2, 100, 271, 0, 0);
    wait_done('1, n);
    chk({tag, "_lat"}, 48'(n), 48'd10);
    chk({tag, "_ready"}, 48'(cmd_ready), 48'd1);
    chk({tag, "_busy"}, 48'(busy), 48'd0);
    settle();
    chk({tag, "_cnt"}, 48'(wq.size()), 48'd8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk({tag, "_pix"}, 48'(wq[i]),
          {8'h0, 16'((i < 4) ? 4810 + i : 5046 + i), mem[(i < 4) ? 100 + i : 367 + i]});
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {4'hA, 10'h0, 10'(i)};
    mem[500] = 24'hFF00FF; mem[501] = 24'h112233; mem[502] = 24'hFF00FF; mem[503] = 24'h445566;
    repeat (2) @(negedge clk);
    chk("rst_ready", 48'(cmd_ready), 48'd1);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_we", 48'(fb_we), 48'd0);
    chk("rst_addr", 48'(fb_addr), 48'd0);
    chk("rst_data", 48'(fb_data), 48'd0);
    chk("rst_src", 48'(src_addr), 48'd0);
    cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_prio", 48'(busy), 48'd0);
    cmd_valid = 0;
    rst = 0;
    @(negedge clk);
    cmd(10, 20, 4, 2, 100, 271, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("prime_src", 48'(src_addr), 48'd100);
    chk("prime_busy", 48'(busy), 48'd1);
    cmd_valid = 0;
    wait_done('1, n);
    settle();
    @(negedge clk);
    run_t1("t1");

    wq.delete();
    cmd(0, 0, 4, 1, 500, 4, 1, 24'hFF00FF);
    wait_done('1, n);
    settle();
    chk("key_cnt", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("key_p0", 48'(wq[0]), {8'h0, 16'd1, 24'h112233});
      chk("key_p1", 48'(wq[1]), {8'h0, 16'd3, 24'h445566});
    end
    @(negedge clk);

    wq.delete();
    cmd(238, 159, 4, 2, 0, 4, 0, 0);
    wait_done('1, n);
    chk("clip_lat", 48'(n), 48'd10);
    settle();
    chk("clip_cnt", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("clip_p0", 48'(wq[0]), {8'h0, 16'd38398, mem[0]});
      chk("clip_p1", 48'(wq[1]), {8'h0, 16'd38399, mem[1]});
    end
    @(negedge clk);

    wq.delete();
    cmd(5, 3, 8, 1, 600, 8, 0, 0);
    wait_done(32'hFFFF_B4A5, n);
    settle();
    chk("stall_cnt", 48'(wq.size()), 48'd8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk("stall_pix", 48'(wq[i]), {8'h0, 16'(725 + i), mem[600 + i]});
    @(negedge clk);

    wq.delete();
    n_done = 0;
    cmd(0, 0, 16, 16, 0, 16, 0, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("abort_we", 48'(fb_we), 48'd0);
    chk("abort_busy", 48'(busy), 48'd0);
    chk("abort_ready", 48'(cmd_ready), 48'd1);
    chk("abort_wcnt", 48'(wq.size()), 48'd2);
    repeat (40) @(negedge clk);
    chk("abort_nodone", 48'(n_done), 48'd0);
    chk("abort_nowr", 48'(wq.size()), 48'd2);
    run_t1("t1b");

    wq.delete();
    cmd(3, 3, 0, 5, 0, 1, 0, 0);
    wait_done('1, n);
    chk("empty_lat", 48'(n), 48'd2);
    chk("empty_ready", 48'(cmd_ready), 48'd1);
    cmd(1, 1, 2, 1, 700, 2, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_prime", 48'(busy), 48'd1);
    chk("b2b_src", 48'(src_addr), 48'd700);
    chk("b2b_done", 48'(done), 48'd0);
    chk("empty_nowr", 48'(wq.size()), 48'd0);
    cmd_valid = 0;
    wait_done('1, n);
    settle();
    chk("b2b_cnt", 48'(wq.size()), 48'd2);
    if (wq.size() == 2) begin
      chk("b2b_p0", 48'(wq[0]), {8'h0, 16'd241, mem[700]});
      chk("b2b_p1", 48'(wq[1]), {8'h0, 16'd242, mem[701]});
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
